// File: rtl/ramb_fifo_ctrl_pkg.sv
// rtl/ramb_fifo_ctrl_pkg.sv - shared constants and types for the SB_RAM40_4K FIFO controller.
package ramb_fifo_ctrl_pkg;

  localparam int RAM_ADDR_W = 11;

  // 256x16 mode: READ_MODE and WRITE_MODE both 0 on the RAM primitive.
  localparam int RAM_READ_MODE  = 0;
  localparam int RAM_WRITE_MODE = 0;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PULL = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_w(input int addr_w);
    return addr_w;
  endfunction

  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ramb_fifo_ctrl.sv
// rtl/ramb_fifo_ctrl.sv - pointer/count/flag control turning an SB_RAM40_4K into a FIFO.
module ramb_fifo_ctrl
  import ramb_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     CLKIN,
  input  logic                     RESETN,
  input  logic                     PUSH,
  input  logic [DATA_W-1:0]        DIN,
  input  logic                     PULL,
  output logic [DATA_W-1:0]        DOUT,
  output logic                     DOUT_VALID,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [ADDR_W:0]          COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  output logic [RAM_ADDR_W-1:0]    RAM_WADDR,
  output logic                     RAM_WE,
  output logic [DATA_W-1:0]        RAM_WDATA,
  output logic [DATA_W-1:0]        RAM_MASK,
  output logic [RAM_ADDR_W-1:0]    RAM_RADDR,
  output logic                     RAM_RE,
  input  logic [DATA_W-1:0]        RAM_RDATA
);

  localparam int PW = ptr_w(ADDR_W);
  localparam int CW = cnt_w(ADDR_W);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_ZERO = '0;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pull_ok;
  fifo_op_e      op;

  // When full, wr_ptr == rd_ptr: rejecting the push keeps the RAM free of a same-address read/write.
  assign push_ok = PUSH & ~FULL;
  assign pull_ok = PULL & ~EMPTY;
  assign op      = fifo_op_e'({push_ok, pull_ok});

  always_comb begin
    count_nxt = COUNT;
    unique case (op)
      OP_PUSH: count_nxt = COUNT + CNT_ONE;
      OP_PULL: count_nxt = COUNT - CNT_ONE;
      default: count_nxt = COUNT;
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      COUNT      <= '0;
      EMPTY      <= 1'b1;
      FULL       <= 1'b0;
      DOUT_VALID <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pull_ok) rd_ptr <= rd_ptr + PTR_ONE;
      COUNT      <= count_nxt;
      EMPTY      <= (count_nxt == CNT_ZERO);
      FULL       <= (count_nxt == CNT_FULL);
      DOUT_VALID <= pull_ok;
      if (PUSH && FULL)  OVERFLOW  <= 1'b1;
      if (PULL && EMPTY) UNDERFLOW <= 1'b1;
    end
  end

  assign RAM_WADDR = {{(RAM_ADDR_W-PW){1'b0}}, wr_ptr};
  assign RAM_RADDR = {{(RAM_ADDR_W-PW){1'b0}}, rd_ptr};
  assign RAM_WE    = push_ok;
  assign RAM_RE    = pull_ok;
  assign RAM_WDATA = DIN;
  assign RAM_MASK  = '0;
  assign DOUT      = RAM_RDATA;

endmodule

// File: tb/tb_ramb_fifo_ctrl.sv
// tb/tb_ramb_fifo_ctrl.sv - directed vector bench for ramb_fifo_ctrl with a behavioural 256x16 RAM.
module tb_ramb_fifo_ctrl;

  logic        CLKIN = 1'b0;
  logic        RESETN;
  logic        PUSH;
  logic [15:0] DIN;
  logic        PULL;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic        FULL;
  logic        EMPTY;
  logic [8:0]  COUNT;
  logic        OVERFLOW;
  logic        UNDERFLOW;
  logic [10:0] RAM_WADDR;
  logic        RAM_WE;
  logic [15:0] RAM_WDATA;
  logic [15:0] RAM_MASK;
  logic [10:0] RAM_RADDR;
  logic        RAM_RE;
  logic [15:0] RAM_RDATA;

  int tests = 0;
  int fails = 0;

  always #5 CLKIN = ~CLKIN;

  ramb_fifo_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLKIN(CLKIN), .RESETN(RESETN), .PUSH(PUSH), .DIN(DIN), .PULL(PULL),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .RAM_WADDR(RAM_WADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA),
    .RAM_MASK(RAM_MASK), .RAM_RADDR(RAM_RADDR), .RAM_RE(RAM_RE),
    .RAM_RDATA(RAM_RDATA)
  );

  // Behavioural SB_RAM40_4K in 256x16 mode: synchronous write, registered read.
  logic [15:0] mem [256];
  always @(posedge CLKIN) begin
    if (RAM_WE) mem[RAM_WADDR[7:0]] <= RAM_WDATA;
    if (RAM_RE) RAM_RDATA <= mem[RAM_RADDR[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic push, input logic [15:0] din, input logic pull);
    PUSH = push;
    DIN  = din;
    PULL = pull;
  endtask

  task automatic next_edge();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    set_in(1'b0, 16'h0, 1'b0);
    #7;
    RESETN = 1'b1;
    next_edge();
  endtask

  typedef struct {
    logic        push;
    logic [15:0] din;
    logic        pull;
    logic        we;
    logic        re;
    logic [8:0]  count;
    logic        empty;
    logic        full;
    logic        valid;
    logic [15:0] dout;
    logic        unf;
  } vec_t;

  vec_t vecs [11];
  logic [15:0] q [$];
  logic [15:0] exp_d;

  initial begin
    RAM_RDATA = '0;
    vecs[0]  = '{1, 16'h0001, 0, 1, 0, 9'd1, 0, 0, 0, 16'h0000, 0};
    vecs[1]  = '{1, 16'h0002, 0, 1, 0, 9'd2, 0, 0, 0, 16'h0000, 0};
    vecs[2]  = '{1, 16'h0003, 0, 1, 0, 9'd3, 0, 0, 0, 16'h0000, 0};
    vecs[3]  = '{0, 16'h0000, 1, 0, 1, 9'd2, 0, 0, 1, 16'h0001, 0};
    vecs[4]  = '{0, 16'h0000, 1, 0, 1, 9'd1, 0, 0, 1, 16'h0002, 0};
    vecs[5]  = '{0, 16'h0000, 1, 0, 1, 9'd0, 1, 0, 1, 16'h0003, 0};
    vecs[6]  = '{0, 16'h0000, 0, 0, 0, 9'd0, 1, 0, 0, 16'h0000, 0};
    vecs[7]  = '{0, 16'h0000, 1, 0, 0, 9'd0, 1, 0, 0, 16'h0000, 1};
    vecs[8]  = '{1, 16'hBEEF, 1, 1, 0, 9'd1, 0, 0, 0, 16'h0000, 1};
    vecs[9]  = '{0, 16'h0000, 1, 0, 1, 9'd0, 1, 0, 1, 16'hBEEF, 1};
    vecs[10] = '{0, 16'h0000, 0, 0, 0, 9'd0, 1, 0, 0, 16'h0000, 1};

    // Reset and idle
    do_reset();
    next_edge();
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_valid", DOUT_VALID, 0);
    chk("rst_we", RAM_WE, 0);
    chk("rst_re", RAM_RE, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_unf", UNDERFLOW, 0);
    chk("mask", RAM_MASK, 0);

    // Table: small push/pull sequence and empty-boundary cases
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].push, vecs[i].din, vecs[i].pull);
      @(negedge CLKIN);
      chk($sformatf("v%0d_we", i), RAM_WE, vecs[i].we);
      chk($sformatf("v%0d_re", i), RAM_RE, vecs[i].re);
      next_edge();
      chk($sformatf("v%0d_count", i), COUNT, vecs[i].count);
      chk($sformatf("v%0d_empty", i), EMPTY, vecs[i].empty);
      chk($sformatf("v%0d_full", i), FULL, vecs[i].full);
      chk($sformatf("v%0d_valid", i), DOUT_VALID, vecs[i].valid);
      if (vecs[i].valid) chk($sformatf("v%0d_dout", i), DOUT, vecs[i].dout);
      chk($sformatf("v%0d_unf", i), UNDERFLOW, vecs[i].unf);
      chk($sformatf("v%0d_ovf", i), OVERFLOW, 0);
    end

    // Fill to 256, overflow, full push+pull, drain with wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      set_in(1'b1, i[15:0], 1'b0);
      @(negedge CLKIN);
      chk("fill_we", RAM_WE, 1);
      chk("fill_waddr", RAM_WADDR, i);
      next_edge();
      chk("fill_full", FULL, (i == 255));
    end
    chk("full_count", COUNT, 256);
    chk("full_empty", EMPTY, 0);
    set_in(1'b1, 16'h1234, 1'b0);
    @(negedge CLKIN);
    chk("ovf_we", RAM_WE, 0);
    next_edge();
    chk("ovf_flag", OVERFLOW, 1);
    chk("ovf_count", COUNT, 256);
    set_in(1'b1, 16'hAAAA, 1'b1);
    @(negedge CLKIN);
    chk("fpp_we", RAM_WE, 0);
    chk("fpp_re", RAM_RE, 1);
    next_edge();
    chk("fpp_count", COUNT, 255);
    chk("fpp_full", FULL, 0);
    chk("fpp_valid", DOUT_VALID, 1);
    chk("fpp_dout", DOUT, 16'h0000);
    chk("fpp_ovf", OVERFLOW, 1);
    for (int i = 1; i < 256; i++) begin
      set_in(1'b0, 16'h0, 1'b1);
      next_edge();
      chk("drain_valid", DOUT_VALID, 1);
      chk("drain_dout", DOUT, i);
    end
    set_in(1'b0, 16'h0, 1'b0);
    next_edge();
    chk("drain_empty", EMPTY, 1);
    chk("drain_count", COUNT, 0);
    chk("drain_valid_end", DOUT_VALID, 0);
    chk("wrap_waddr", RAM_WADDR, 0);
    chk("wrap_raddr", RAM_RADDR, 0);
    chk("drain_ovf_sticky", OVERFLOW, 1);

    // Steady state at COUNT=4, then asynchronous reset mid-stream
    do_reset();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h0100 + i[15:0], 1'b0);
      q.push_back(16'h0100 + i[15:0]);
      next_edge();
    end
    chk("ss_pre_count", COUNT, 4);
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, 16'h0200 + i[15:0], 1'b1);
      exp_d = q.pop_front();
      q.push_back(16'h0200 + i[15:0]);
      next_edge();
      chk("ss_count", COUNT, 4);
      chk("ss_valid", DOUT_VALID, 1);
      chk("ss_dout", DOUT, exp_d);
    end
    #2;
    RESETN = 1'b0;
    set_in(1'b0, 16'h0, 1'b0);
    #1;
    chk("arst_count", COUNT, 0);
    chk("arst_empty", EMPTY, 1);
    chk("arst_full", FULL, 0);
    chk("arst_valid", DOUT_VALID, 0);
    chk("arst_ovf", OVERFLOW, 0);
    chk("arst_unf", UNDERFLOW, 0);
    chk("arst_waddr", RAM_WADDR, 0);
    chk("arst_raddr", RAM_RADDR, 0);
    next_edge();
    RESETN = 1'b1;
    next_edge();
    set_in(1'b1, 16'h5555, 1'b0);
    @(negedge CLKIN);
    chk("post_waddr", RAM_WADDR, 0);
    chk("post_we", RAM_WE, 1);
    next_edge();
    set_in(1'b0, 16'h0, 1'b1);
    @(negedge CLKIN);
    chk("post_raddr", RAM_RADDR, 0);
    chk("post_re", RAM_RE, 1);
    next_edge();
    set_in(1'b0, 16'h0, 1'b0);
    chk("post_valid", DOUT_VALID, 1);
    chk("post_dout", DOUT, 16'h5555);
    chk("post_empty", EMPTY, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
